// File: rtl/lvt_mpram.sv
// Multi-ported RAM: replicated 1W/1R banks per (write, read) port pair, with a
// live value table recording which write port last wrote each address.
module lvt_mpram #(
  parameter int NUM_WR    = 2,
  parameter int NUM_RD    = 2,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 7,
  parameter int WR_BYPASS = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        wr_en,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  input  logic [NUM_WR*DATA_W-1:0] wr_data,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid,
  output logic                     wr_conflict
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int SEL_W = $clog2(NUM_WR);

  logic [SEL_W-1:0]               lvt_sel [DEPTH];
  logic [DEPTH-1:0]               lvt_live;
  logic [NUM_WR*NUM_RD*DATA_W-1:0] bank_rd;
  logic [NUM_RD*DATA_W-1:0]       rd_next;
  logic                           conflict;

  // Bank (w, r) is written by port w only and read by port r only.
  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    for (genvar r = 0; r < NUM_RD; r++) begin : g_rd
      logic [DATA_W-1:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (wr_en[w]) mem[wr_addr[w*ADDR_W +: ADDR_W]] <= wr_data[w*DATA_W +: DATA_W];
      end

      assign bank_rd[(w*NUM_RD + r)*DATA_W +: DATA_W] = mem[rd_addr[r*ADDR_W +: ADDR_W]];
    end
  end

  // Ascending port order lets the highest-numbered port win on a shared address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) lvt_sel[i] <= '0;
      lvt_live <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (wr_en[p]) begin
          lvt_sel[wr_addr[p*ADDR_W +: ADDR_W]]  <= SEL_W'(p);
          lvt_live[wr_addr[p*ADDR_W +: ADDR_W]] <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    conflict = 1'b0;
    for (int i = 0; i < NUM_WR; i++) begin
      for (int j = i + 1; j < NUM_WR; j++) begin
        if (wr_en[i] && wr_en[j] &&
            wr_addr[i*ADDR_W +: ADDR_W] == wr_addr[j*ADDR_W +: ADDR_W])
          conflict = 1'b1;
      end
    end
  end

  always_comb begin
    rd_next = '0;
    for (int r = 0; r < NUM_RD; r++) begin
      if (lvt_live[rd_addr[r*ADDR_W +: ADDR_W]])
        rd_next[r*DATA_W +: DATA_W] =
          bank_rd[(int'(lvt_sel[rd_addr[r*ADDR_W +: ADDR_W]])*NUM_RD + r)*DATA_W +: DATA_W];
      if (WR_BYPASS != 0) begin
        for (int p = 0; p < NUM_WR; p++) begin
          if (wr_en[p] && wr_addr[p*ADDR_W +: ADDR_W] == rd_addr[r*ADDR_W +: ADDR_W])
            rd_next[r*DATA_W +: DATA_W] = wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data     <= '0;
      rd_valid    <= '0;
      wr_conflict <= 1'b0;
    end else begin
      rd_valid    <= rd_en;
      wr_conflict <= conflict;
      for (int r = 0; r < NUM_RD; r++) begin
        if (rd_en[r]) rd_data[r*DATA_W +: DATA_W] <= rd_next[r*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_lvt_mpram.sv
// Bench for lvt_mpram: directed scenarios on 2W/2R instances (with and without
// bypass) and randomized traffic on a 4W/3R instance against an array model.
module tb_lvt_mpram;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0]  wr_en_ab;
  logic [7:0]  wr_addr_ab;
  logic [15:0] wr_data_ab;
  logic [1:0]  rd_en_ab;
  logic [7:0]  rd_addr_ab;
  logic [15:0] rd_data_a, rd_data_b;
  logic [1:0]  rd_valid_a, rd_valid_b;
  logic        wr_conflict_a, wr_conflict_b;

  logic [3:0]  wr_en_c;
  logic [15:0] wr_addr_c;
  logic [31:0] wr_data_c;
  logic [2:0]  rd_en_c;
  logic [11:0] rd_addr_c;
  logic [23:0] rd_data_c;
  logic [2:0]  rd_valid_c;
  logic        wr_conflict_c;

  lvt_mpram #(.NUM_WR(2), .NUM_RD(2), .DATA_W(8), .ADDR_W(4), .WR_BYPASS(0)) u_a (
    .clk(clk), .rst(rst), .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab),
    .rd_en(rd_en_ab), .rd_addr(rd_addr_ab), .rd_data(rd_data_a), .rd_valid(rd_valid_a),
    .wr_conflict(wr_conflict_a));

  lvt_mpram #(.NUM_WR(2), .NUM_RD(2), .DATA_W(8), .ADDR_W(4), .WR_BYPASS(1)) u_b (
    .clk(clk), .rst(rst), .wr_en(wr_en_ab), .wr_addr(wr_addr_ab), .wr_data(wr_data_ab),
    .rd_en(rd_en_ab), .rd_addr(rd_addr_ab), .rd_data(rd_data_b), .rd_valid(rd_valid_b),
    .wr_conflict(wr_conflict_b));

  lvt_mpram #(.NUM_WR(4), .NUM_RD(3), .DATA_W(8), .ADDR_W(4), .WR_BYPASS(1)) u_c (
    .clk(clk), .rst(rst), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .rd_valid(rd_valid_c),
    .wr_conflict(wr_conflict_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en_ab = '0; wr_addr_ab = '0; wr_data_ab = '0;
    rd_en_ab = '0; rd_addr_ab = '0;
  endtask

  task automatic wr(input int p, input logic [3:0] a, input logic [7:0] d);
    wr_en_ab[p] = 1'b1;
    wr_addr_ab[p*4 +: 4] = a;
    wr_data_ab[p*8 +: 8] = d;
  endtask

  task automatic rd(input int r, input logic [3:0] a);
    rd_en_ab[r] = 1'b1;
    rd_addr_ab[r*4 +: 4] = a;
  endtask

  task automatic test_reset();
    idle();
    wr_en_c = '0; wr_addr_c = '0; wr_data_c = '0; rd_en_c = '0; rd_addr_c = '0;
    rst = 1'b0;
    tick(); tick();
    n_checks++;
    if ({rd_data_a, rd_valid_a, wr_conflict_a} !== 19'd0) begin
      n_fail++; $display("FAIL reset_a: got %h expected 0", {rd_data_a, rd_valid_a, wr_conflict_a});
    end
    n_checks++;
    if ({rd_data_c, rd_valid_c, wr_conflict_c} !== 28'd0) begin
      n_fail++; $display("FAIL reset_c: got %h expected 0", {rd_data_c, rd_valid_c, wr_conflict_c});
    end
    rst = 1'b1;
    rd(0, 4'd5);
    tick();
    n_checks++;
    if (rd_valid_a !== 2'b01 || rd_data_a[7:0] !== 8'h00 || wr_conflict_a !== 1'b0) begin
      n_fail++; $display("FAIL first_read: got v=%b d=%h c=%b expected v=01 d=00 c=0",
                         rd_valid_a, rd_data_a[7:0], wr_conflict_a);
    end
    idle();
  endtask

  task automatic test_interleave();
    idle(); wr(0, 4'd3, 8'hA1); tick();
    idle(); wr(1, 4'd3, 8'hB2); tick();
    n_checks++;
    if (wr_conflict_a !== 1'b0) begin
      n_fail++; $display("FAIL no_conflict: got %b expected 0", wr_conflict_a);
    end
    idle(); rd(0, 4'd3); rd(1, 4'd3); tick();
    n_checks++;
    if (rd_data_a !== 16'hB2B2 || rd_valid_a !== 2'b11) begin
      n_fail++; $display("FAIL interleave_b2: got d=%h v=%b expected d=b2b2 v=11", rd_data_a, rd_valid_a);
    end
    idle(); wr(0, 4'd3, 8'hC3); tick();
    idle(); rd(0, 4'd3); rd(1, 4'd3); tick();
    n_checks++;
    if (rd_data_b !== 16'hC3C3) begin
      n_fail++; $display("FAIL interleave_c3: got %h expected c3c3", rd_data_b);
    end
    idle(); tick();
    n_checks++;
    if (rd_valid_a !== 2'b00 || rd_data_a !== 16'hC3C3) begin
      n_fail++; $display("FAIL hold: got d=%h v=%b expected d=c3c3 v=00", rd_data_a, rd_valid_a);
    end
  endtask

  task automatic test_conflict();
    idle(); wr(0, 4'd7, 8'h11); wr(1, 4'd7, 8'h22); tick();
    n_checks++;
    if (wr_conflict_a !== 1'b1) begin
      n_fail++; $display("FAIL conflict_pulse: got %b expected 1", wr_conflict_a);
    end
    idle(); tick();
    n_checks++;
    if (wr_conflict_a !== 1'b0) begin
      n_fail++; $display("FAIL conflict_clear: got %b expected 0", wr_conflict_a);
    end
    rd(1, 4'd7); tick();
    n_checks++;
    if (rd_data_a[15:8] !== 8'h22 || rd_valid_a !== 2'b10) begin
      n_fail++; $display("FAIL conflict_winner: got d=%h v=%b expected d=22 v=10", rd_data_a[15:8], rd_valid_a);
    end
    idle();
  endtask

  task automatic test_read_during_write();
    idle(); wr(1, 4'd9, 8'h40); tick();
    idle(); wr(0, 4'd9, 8'h55); rd(0, 4'd9); tick();
    n_checks++;
    if (rd_data_a[7:0] !== 8'h40) begin
      n_fail++; $display("FAIL rdw_nobypass: got %h expected 40", rd_data_a[7:0]);
    end
    n_checks++;
    if (rd_data_b[7:0] !== 8'h55) begin
      n_fail++; $display("FAIL rdw_bypass: got %h expected 55", rd_data_b[7:0]);
    end
    idle(); rd(0, 4'd9); tick();
    n_checks++;
    if (rd_data_a[7:0] !== 8'h55 || rd_data_b[7:0] !== 8'h55) begin
      n_fail++; $display("FAIL rdw_after: got a=%h b=%h expected 55", rd_data_a[7:0], rd_data_b[7:0]);
    end
    idle(); wr(0, 4'd10, 8'h66); wr(1, 4'd10, 8'h77); rd(1, 4'd10); tick();
    n_checks++;
    if (rd_data_a[15:8] !== 8'h00 || rd_data_b[15:8] !== 8'h77) begin
      n_fail++; $display("FAIL rdw_priority: got a=%h b=%h expected a=00 b=77", rd_data_a[15:8], rd_data_b[15:8]);
    end
    idle();
  endtask

  task automatic test_random();
    logic [7:0]  mdl [16];
    logic [23:0] exp_data;
    logic [2:0]  exp_valid;
    logic        exp_conf;
    logic [3:0]  a, base;
    logic [7:0]  v;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    exp_data = '0;
    for (int cyc = 0; cyc < 256; cyc++) begin
      wr_en_c = 4'($urandom);
      base    = 4'($urandom);
      for (int p = 0; p < 4; p++) begin
        wr_addr_c[p*4 +: 4] = (cyc < 128) ? base + 4'(p*5) : 4'($urandom);
        wr_data_c[p*8 +: 8] = 8'($urandom);
      end
      rd_en_c = 3'($urandom);
      for (int r = 0; r < 3; r++) rd_addr_c[r*4 +: 4] = 4'($urandom);

      exp_conf = 1'b0;
      for (int i = 0; i < 4; i++)
        for (int j = i + 1; j < 4; j++)
          if (wr_en_c[i] && wr_en_c[j] && wr_addr_c[i*4 +: 4] == wr_addr_c[j*4 +: 4]) exp_conf = 1'b1;
      for (int r = 0; r < 3; r++) begin
        if (rd_en_c[r]) begin
          a = rd_addr_c[r*4 +: 4];
          v = mdl[a];
          for (int p = 0; p < 4; p++)
            if (wr_en_c[p] && wr_addr_c[p*4 +: 4] == a) v = wr_data_c[p*8 +: 8];
          exp_data[r*8 +: 8] = v;
        end
      end
      for (int p = 0; p < 4; p++)
        if (wr_en_c[p]) mdl[wr_addr_c[p*4 +: 4]] = wr_data_c[p*8 +: 8];
      exp_valid = rd_en_c;

      tick();
      n_checks++;
      if (rd_valid_c !== exp_valid) begin
        n_fail++; $display("FAIL rand_valid cyc %0d: got %b expected %b", cyc, rd_valid_c, exp_valid);
      end
      n_checks++;
      if (rd_data_c !== exp_data) begin
        n_fail++; $display("FAIL rand_data cyc %0d: got %h expected %h", cyc, rd_data_c, exp_data);
      end
      n_checks++;
      if (wr_conflict_c !== exp_conf) begin
        n_fail++; $display("FAIL rand_conflict cyc %0d: got %b expected %b", cyc, wr_conflict_c, exp_conf);
      end
    end
    wr_en_c = '0; rd_en_c = '0;
  endtask

  task automatic test_mid_reset();
    idle(); wr(0, 4'd2, 8'hEE); tick();
    idle(); rd(0, 4'd2); tick();
    n_checks++;
    if (rd_valid_a !== 2'b01 || rd_data_a[7:0] !== 8'hEE) begin
      n_fail++; $display("FAIL pre_reset_read: got v=%b d=%h expected v=01 d=ee", rd_valid_a, rd_data_a[7:0]);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (rd_valid_a !== 2'b00 || rd_data_a !== 16'h0000) begin
      n_fail++; $display("FAIL async_reset: got v=%b d=%h expected v=00 d=0000", rd_valid_a, rd_data_a);
    end
    tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (rd_valid_a !== 2'b01 || rd_data_a[7:0] !== 8'h00) begin
      n_fail++; $display("FAIL post_reset_read: got v=%b d=%h expected v=01 d=00", rd_valid_a, rd_data_a[7:0]);
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_interleave();
    test_conflict();
    test_read_during_write();
    test_random();
    test_mid_reset();
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
